// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: default widths, depth derivation
// and the bit layout of one packed entry {valid, done, w, dest, value}.
package reorder_buffer_pkg;

  localparam int ID_SIZE_DEFAULT          = 32'sd2;
  localparam int REG_ADDRESS_SIZE_DEFAULT = 32'sd5;
  localparam int REG_SIZE_DEFAULT         = 32'sd32;

  function automatic int rob_depth(input int id_size);
    return 32'sd1 <<< id_size;
  endfunction

  // Packed entry, LSB first: value, dest, w, done, valid
  function automatic int ent_value_lsb();
    return 32'sd0;
  endfunction

  function automatic int ent_dest_lsb(input int dw);
    return dw;
  endfunction

  function automatic int ent_w_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int ent_done_bit(input int aw, input int dw);
    return aw + dw + 32'sd1;
  endfunction

  function automatic int ent_valid_bit(input int aw, input int dw);
    return aw + dw + 32'sd2;
  endfunction

  function automatic int ent_width(input int aw, input int dw);
    return aw + dw + 32'sd3;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode / execution-unit / register-bank side signals of the reorder buffer.
interface reorder_buffer_if #(
  parameter int REG_ADDRESS_SIZE = reorder_buffer_pkg::REG_ADDRESS_SIZE_DEFAULT,
  parameter int REG_SIZE         = reorder_buffer_pkg::REG_SIZE_DEFAULT,
  parameter int ID_SIZE          = reorder_buffer_pkg::ID_SIZE_DEFAULT
);
  logic                        RB_alloc;
  logic [REG_ADDRESS_SIZE-1:0] RB_alloc_dest;
  logic                        RB_alloc_w;
  logic [ID_SIZE-1:0]          RB_tail;
  logic [ID_SIZE-1:0]          RB_head;
  logic [ID_SIZE:0]            RB_count;
  logic                        RB_stall;
  logic                        RB_alu_valid;
  logic [ID_SIZE-1:0]          RB_alu_id;
  logic [REG_SIZE-1:0]         RB_alu_value;
  logic                        RB_mul_valid;
  logic [ID_SIZE-1:0]          RB_mul_id;
  logic [REG_SIZE-1:0]         RB_mul_value;
  logic                        RB_flush;
  logic [REG_ADDRESS_SIZE-1:0] RB_Wat;
  logic [REG_SIZE-1:0]         RB_Wvalue;
  logic                        RB_We;

  modport master (
    output RB_alloc, RB_alloc_dest, RB_alloc_w,
    output RB_alu_valid, RB_alu_id, RB_alu_value,
    output RB_mul_valid, RB_mul_id, RB_mul_value,
    output RB_flush,
    input  RB_tail, RB_head, RB_count, RB_stall,
    input  RB_Wat, RB_Wvalue, RB_We
  );

  modport slave (
    input  RB_alloc, RB_alloc_dest, RB_alloc_w,
    input  RB_alu_valid, RB_alu_id, RB_alu_value,
    input  RB_mul_valid, RB_mul_id, RB_mul_value,
    input  RB_flush,
    output RB_tail, RB_head, RB_count, RB_stall,
    output RB_Wat, RB_Wvalue, RB_We
  );
endinterface

// File: rtl/rob_storage.sv
// Reorder buffer entry array: one allocate port, two completion ports and a
// head read port returning the packed entry addressed by head_id.
module rob_storage
  import reorder_buffer_pkg::*;
#(
  parameter int AW = REG_ADDRESS_SIZE_DEFAULT,
  parameter int DW = REG_SIZE_DEFAULT,
  parameter int IW = ID_SIZE_DEFAULT,
  localparam int DEPTH = rob_depth(IW),
  localparam int EW    = ent_width(AW, DW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          alloc_en,
  input  logic [IW-1:0] alloc_id,
  input  logic          alloc_w,
  input  logic [AW-1:0] alloc_dest,
  input  logic          alu_valid,
  input  logic [IW-1:0] alu_id,
  input  logic [DW-1:0] alu_value,
  input  logic          mul_valid,
  input  logic [IW-1:0] mul_id,
  input  logic [DW-1:0] mul_value,
  input  logic          commit_en,
  input  logic [IW-1:0] head_id,
  output logic [EW-1:0] head_entry
);
  localparam int VB = ent_valid_bit(AW, DW);
  localparam int DB = ent_done_bit(AW, DW);
  localparam int WB = ent_w_bit(AW, DW);
  localparam int AL = ent_dest_lsb(DW);
  localparam int VL = ent_value_lsb();

  logic [DEPTH-1:0] valid_r, done_r, w_r;
  logic [AW-1:0]    dest_r  [DEPTH];
  logic [DW-1:0]    value_r [DEPTH];
  logic [DEPTH-1:0] alu_hit_s, mul_hit_s;

  // Decode completion IDs into per-entry hits against entries already live
  always_comb begin
    alu_hit_s = '0;
    mul_hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alu_hit_s[i] = alu_valid && (alu_id == IW'(i)) && valid_r[i];
      mul_hit_s[i] = mul_valid && (mul_id == IW'(i)) && valid_r[i];
    end
  end

  // Entry state: flush beats allocate beats commit beats completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      done_r  <= '0;
      w_r     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_r[i]  <= '0;
        value_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          valid_r[i] <= 1'b0;
          done_r[i]  <= 1'b0;
        end else if (alloc_en && (alloc_id == IW'(i))) begin
          valid_r[i] <= 1'b1;
          done_r[i]  <= 1'b0;
          w_r[i]     <= alloc_w;
          dest_r[i]  <= alloc_dest;
        end else if (commit_en && (head_id == IW'(i))) begin
          valid_r[i] <= 1'b0;
          done_r[i]  <= 1'b0;
        end else if (alu_hit_s[i] || mul_hit_s[i]) begin
          done_r[i] <= 1'b1;
        end
        // ALU takes the slot if both units name the same entry
        if (!flush && alu_hit_s[i]) begin
          value_r[i] <= alu_value;
        end else if (!flush && mul_hit_s[i]) begin
          value_r[i] <= mul_value;
        end
      end
    end
  end

  // Pack the head entry for the commit logic
  always_comb begin
    head_entry             = '0;
    head_entry[VB]         = valid_r[head_id];
    head_entry[DB]         = done_r[head_id];
    head_entry[WB]         = w_r[head_id];
    head_entry[AL +: AW]   = dest_r[head_id];
    head_entry[VL +: DW]   = value_r[head_id];
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order commit controller: allocates entries at the tail, retires completed
// entries from the head one per cycle onto the register-bank write port.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int REG_ADDRESS_SIZE = REG_ADDRESS_SIZE_DEFAULT,
  parameter int REG_SIZE         = REG_SIZE_DEFAULT,
  parameter int ID_SIZE          = ID_SIZE_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave rb
);
  localparam int DEPTH = rob_depth(ID_SIZE);
  localparam int EW    = ent_width(REG_ADDRESS_SIZE, REG_SIZE);
  localparam int VB    = ent_valid_bit(REG_ADDRESS_SIZE, REG_SIZE);
  localparam int DB    = ent_done_bit(REG_ADDRESS_SIZE, REG_SIZE);
  localparam int WB    = ent_w_bit(REG_ADDRESS_SIZE, REG_SIZE);
  localparam int AL    = ent_dest_lsb(REG_SIZE);
  localparam int VL    = ent_value_lsb();

  logic [ID_SIZE-1:0]          head_r, tail_r;
  logic [ID_SIZE:0]            count_r;
  logic                        we_r;
  logic [REG_ADDRESS_SIZE-1:0] wat_r;
  logic [REG_SIZE-1:0]         wvalue_r;
  logic [EW-1:0]               head_entry_s;
  logic                        stall_s, alloc_ok_s, commit_s;

  rob_storage #(.AW(REG_ADDRESS_SIZE), .DW(REG_SIZE), .IW(ID_SIZE)) u_storage (
    .clk        (clk),
    .reset      (reset),
    .flush      (rb.RB_flush),
    .alloc_en   (alloc_ok_s),
    .alloc_id   (tail_r),
    .alloc_w    (rb.RB_alloc_w),
    .alloc_dest (rb.RB_alloc_dest),
    .alu_valid  (rb.RB_alu_valid),
    .alu_id     (rb.RB_alu_id),
    .alu_value  (rb.RB_alu_value),
    .mul_valid  (rb.RB_mul_valid),
    .mul_id     (rb.RB_mul_id),
    .mul_value  (rb.RB_mul_value),
    .commit_en  (commit_s),
    .head_id    (head_r),
    .head_entry (head_entry_s)
  );

  // Stall comes from the count register only, so a same-cycle commit cannot release it
  always_comb begin
    stall_s    = (count_r == (ID_SIZE+1)'(DEPTH));
    alloc_ok_s = rb.RB_alloc && !stall_s;
    commit_s   = head_entry_s[VB] && head_entry_s[DB];
  end

  // Pointers, occupancy and the registered commit write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      we_r     <= 1'b0;
      wat_r    <= '0;
      wvalue_r <= '0;
    end else if (rb.RB_flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      we_r    <= 1'b0;
    end else begin
      tail_r  <= tail_r + ID_SIZE'(alloc_ok_s);
      head_r  <= head_r + ID_SIZE'(commit_s);
      count_r <= count_r + (ID_SIZE+1)'(alloc_ok_s) - (ID_SIZE+1)'(commit_s);
      we_r    <= commit_s && head_entry_s[WB];
      if (commit_s) begin
        wat_r    <= head_entry_s[AL +: REG_ADDRESS_SIZE];
        wvalue_r <= head_entry_s[VL +: REG_SIZE];
      end
    end
  end

  assign rb.RB_tail   = tail_r;
  assign rb.RB_head   = head_r;
  assign rb.RB_count  = count_r;
  assign rb.RB_stall  = stall_s;
  assign rb.RB_We     = we_r;
  assign rb.RB_Wat    = wat_r;
  assign rb.RB_Wvalue = wvalue_r;
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order commit controller between the decode/issue stage and the register bank write port. Every issued instruction gets an entry tagged with the current tail ID. The ALU and MUL units complete entries out of order by ID. The block retires completed entries strictly in program order, at most one per cycle, and drives the single register-bank write port. It raises the ROB stall to decode when full.

## Interface
Parameters:
- REG_ADDRESS_SIZE, 5, register address width
- REG_SIZE, 32, register data width
- ID_SIZE, 2, entry ID width; DEPTH = 2**ID_SIZE entries

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- RB_alloc  in  1  decode issues one instruction this cycle
- RB_alloc_dest  in  REG_ADDRESS_SIZE  destination register of the issued instruction
- RB_alloc_w  in  1  issued instruction writes a register
- RB_tail  out  ID_SIZE  ID assigned to the next allocation
- RB_head  out  ID_SIZE  ID of the oldest entry
- RB_count  out  ID_SIZE+1  occupied entries
- RB_stall  out  1  buffer full
- RB_alu_valid, RB_mul_valid  in  1  unit completes an entry this cycle
- RB_alu_id, RB_mul_id  in  ID_SIZE  ID being completed
- RB_alu_value, RB_mul_value  in  REG_SIZE  result
- RB_flush  in  1  discard all entries (branch redirect)
- RB_Wat  out  REG_ADDRESS_SIZE  commit write address
- RB_Wvalue  out  REG_SIZE  commit write data
- RB_We  out  1  commit write enable, one-cycle pulse

## Operation
- Storage: a circular array of DEPTH entries. Each entry holds {valid, done, w, dest, value}. head and tail are ID_SIZE-bit pointers and wrap mod DEPTH. count is ID_SIZE+1 bits.
- Allocate: if RB_alloc && !RB_stall, entry[tail] = {1, 0, RB_alloc_w, RB_alloc_dest, x} and tail+1. RB_alloc while RB_stall is ignored.
- Complete: if RB_alu_valid and entry[RB_alu_id].valid, store the value and set done. MUL is handled the same way.
  - Completion to an invalid entry is ignored.
  - ALU and MUL with the same ID in one cycle is illegal. ALU wins, and the bench flags it with an assertion.
- Commit: if entry[head].valid && entry[head].done at the start of the cycle, clear valid and advance head+1. On that edge, register RB_We = entry.w, RB_Wat = dest and RB_Wvalue = value. Otherwise RB_We = 0.
  - Entries with w=0 retire silently, with RB_We = 0.
- count next = count + alloc_accepted − commit.
- RB_stall = (count == DEPTH), decoded combinationally from the count register. A commit in the same cycle does not release the stall; the stall releases on the following cycle.
- Flush: synchronous. It has priority over alloc, complete and commit. It clears all valid bits, head = tail = 0, count = 0, RB_We = 0 next cycle.
- Reset values: head = tail = 0, count = 0, all valid/done = 0, RB_We = 0, RB_Wat = 0, RB_Wvalue = 0, RB_stall = 0.

## Timing
- Allocate at edge N: RB_tail increments after N. The entry can be completed from the N+1 cycle onward.
- Complete at edge N: done is set after N, the entry commits at edge N+1, and RB_We is high for the cycle after N+1. Minimum complete-to-write latency is 2 edges.
- Throughput: one allocation and one commit per cycle, concurrently. Two completions per cycle if the IDs differ.
- Full at count == DEPTH. Empty at count == 0, with head == tail in both cases; count disambiguates.
- A completion arriving on the same edge as the head check does not commit that edge.
- Reset asserted mid-operation clears state asynchronously. RB_We drops immediately with no partial write. Operation resumes on the first edge after reset deasserts.

## Structure
- Shared package holds the entry field layout (valid/done/w/dest/value offsets), ID_SIZE default and DEPTH derivation, used by decode and the ALU/MUL wrappers.
- One sub-module, rob_storage: the entry array with one allocate port, two completion ports and a head read port. reorder_buffer keeps the pointers, count, stall, flush and commit register.

## Test plan
- Reset, alloc 4 entries (dest 1..4, w=1), complete ALU ids 3,2,1,0 in reverse -> RB_We pulses in order Wat = 1,2,3,4, one per cycle. Writes start 2 edges after id 0 completes.
- Alloc 4 with DEPTH=4 -> RB_stall=1, count=4. A 5th alloc is ignored and tail stays 0. Complete id 0 -> commit, and the stall clears one cycle after the commit.
- Same cycle: ALU id 1 = 0xAAAA, MUL id 2 = 0x5555 with head=1 -> both done. Commits Wvalue 0xAAAA then 0x5555 on consecutive cycles.
- Entry with w=0 completed -> head advances, count decrements, RB_We stays 0.
- 3 entries, ids 0,1 done, assert RB_flush -> next cycle count=0, head=tail=0, no RB_We. A later completion to id 1 is ignored.
- Reset low mid-stream with count=3 -> all outputs zero immediately. After release, alloc gets RB_tail=0.
